dem_sdm_quantizer: RTL
======================

// Module: dem_sdm_quantizer
// PURPOSE
//  Second-order error-feedback delta-sigma quantizer feeding the switching-block tree (SwitchingBlockLayers).
//  Reduces 16-bit signed PCM samples to a 9-level code (-8..+8 unit elements, even steps).
//  Quantization noise is shaped by NTF (1-z^-1)^2. The tree splits the code across 8 unit elements.
//  Optional LFSR dither and an overload guard that resets the loop state.
// PARAMETERS
//  INPUT_WIDTH  16     sample width; taken from lib_switchblock_pkg.
//  ACC_WIDTH    20     internal loop width (v, e1, e2), signed.
//  QSHIFT       13     log2 of quantizer step; QSTEP = 8192.
//  QMAX         4      quantizer index clamp, q in [-QMAX, QMAX].
//  OVL_LIMIT    40960  |v| above this value is an overload.
//  DITHER_BITS  4      dither amplitude in bits, two's complement.
// PORTS
//  clk_i        in   1            clock, rising edge
//  reset_i      in   1            synchronous, active-high reset
//  x_in_i       in   INPUT_WIDTH  signed PCM sample
//  in_valid_i   in   1            x_in_i is valid this cycle; the sample is accepted
//  dither_en_i  in   1            add LFSR dither to the accepted sample
//  x_out_o      out  INPUT_WIDTH  signed code 2*q (-8..+8), drives SwitchingBlockLayers.x_in_i
//  out_valid_o  out  1            x_out_o updated this cycle
//  overflow_o   out  1            one-cycle pulse, overload detected on the sample now output
//  ovl_count_o  out  8            saturating overload counter
// BEHAVIOUR
//  - Reset (sync, high): x_out_o=0, out_valid_o=0, overflow_o=0, ovl_count_o=0, e1=e2=0, stage-1 valid=0, LFSR=16'hACE1.
//  - Stage 1 (accepted cycle):
//      s1 <= sext(x_in_i) + (dither_en_i ? sext(lfsr[DITHER_BITS-1:0]) : 0); s1_valid <= in_valid_i.
//      LFSR advances only on accepted samples: taps x^16+x^14+x^13+x^11, Fibonacci, shift left.
//  - Stage 2 (when s1_valid=1), all signed at ACC_WIDTH:
//      v = s1 - 2*e1 + e2
//      q = clamp((v + QSTEP/2) >>> QSHIFT, -QMAX, QMAX)
//      y = q*QSTEP; e = y - v; then e2 <= e1, e1 <= e.
//      x_out_o <= 2*q; out_valid_o <= 1.
//  - When s1_valid=0: out_valid_o <= 0; x_out_o, e1 and e2 hold.
//  - Latency: 2 cycles, accepted input to out_valid_o. Throughput: 1 sample/cycle, no backpressure.
//  - Overload, |v| > OVL_LIMIT:
//      the sample is still output with clamped q;
//      overflow_o=1 with that out_valid_o;
//      e1 and e2 are forced to 0 instead of updating;
//      ovl_count_o increments and saturates at 255.
//  - Clamp without overload: no flag; e is kept at full value.
//  - in_valid_i gaps: the loop state freezes; the noise-shaping loop resumes on the next sample.
//  - Reset during operation: the in-flight sample is dropped; the first output after reset is computed with e1=e2=0.
//  - Arithmetic: no wrap is permitted. ACC_WIDTH covers |v| <= 2^15 + 3*2^15 with margin.
// STRUCTURE
//  - lib_switchblock_pkg adds:
//      constants QSHIFT, QSTEP, QMAX, ACC_WIDTH, OVL_LIMIT, LFSR_SEED=16'hACE1;
//      typedef acc_t = logic signed [ACC_WIDTH-1:0].
//  - Sub-module dem_dither_lfsr: ports clk_i, reset_i, adv_i, lfsr_o[15:0].
//  - Top level holds the two pipeline stages, the quantizer/clamp logic and the overload counter.
// TESTING
//  1. Reset: hold reset_i 2 cycles with in_valid_i=1 -> all outputs 0. First out_valid_o occurs 2 cycles after release.
//  2. x=0 constant, dither off -> x_out_o=0 every cycle; overflow_o never asserted.
//  3. x=8192 constant, dither off -> x_out_o=+2 every sample. x=-32768 -> x_out_o=-8 every sample.
//  4. x=4096, dither off:
//       x_out_o sequence starts +2, 0, ...
//       the sum of x_out_o over 256 samples is 256 +/- 4, i.e. the mean is 1 unit.
//       Bit-exact against a reference model.
//  5. Instance with OVL_LIMIT=30000, x=32000 -> the first output is +8 with overflow_o=1; e1=e2=0 afterwards; ovl_count_o=1.
//  6. Gaps, dither on: in_valid_i toggling 1/0 with x=12345 -> out_valid_o mirrors in_valid_i delayed 2 cycles.
//       The output stream equals the gap-free stream with the same samples and dither.
//       The LFSR advances only on accepted samples.

Source files
------------

// File: rtl/lib_switchblock_pkg.sv
// Shared constants and helpers for the switching-block DEM path: loop widths,
// quantizer step, overload threshold and the dither LFSR recurrence.
package lib_switchblock_pkg;

    localparam int INPUT_WIDTH = 16;
    localparam int ACC_WIDTH   = 20;
    localparam int QSHIFT      = 13;
    localparam int QSTEP       = 1 << QSHIFT;
    localparam int QMAX        = 4;
    localparam int OVL_LIMIT   = 40960;
    localparam int DITHER_BITS = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    // Fibonacci LFSR x^16+x^14+x^13+x^11, shifting left, feedback into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/dem_dither_lfsr.sv
// 16-bit dither source; steps once per accepted sample so gaps in the input
// stream do not change the dither sequence seen by the loop.
module dem_dither_lfsr (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        adv_i,
    output logic [15:0] lfsr_o
);
    import lib_switchblock_pkg::*;

    logic [15:0] r_lfsr;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_lfsr <= LFSR_SEED;
        end else if (adv_i) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign lfsr_o = r_lfsr;

endmodule

// File: rtl/dem_sdm_quantizer.sv
// Second-order error-feedback delta-sigma quantizer: 16-bit PCM in, 9-level
// even code (2*q, q in -QMAX..QMAX) out, NTF (1-z^-1)^2, optional LFSR dither.
module dem_sdm_quantizer #(
    parameter int INPUT_WIDTH = lib_switchblock_pkg::INPUT_WIDTH,
    parameter int ACC_WIDTH   = lib_switchblock_pkg::ACC_WIDTH,
    parameter int QSHIFT      = lib_switchblock_pkg::QSHIFT,
    parameter int QMAX        = lib_switchblock_pkg::QMAX,
    parameter int OVL_LIMIT   = lib_switchblock_pkg::OVL_LIMIT,
    parameter int DITHER_BITS = lib_switchblock_pkg::DITHER_BITS
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic signed [INPUT_WIDTH-1:0] x_in_i,
    input  logic                          in_valid_i,
    input  logic                          dither_en_i,
    output logic signed [INPUT_WIDTH-1:0] x_out_o,
    output logic                          out_valid_o,
    output logic                          overflow_o,
    output logic [7:0]                    ovl_count_o
);
    // Handshake: in_valid_i qualifies x_in_i and there is no ready, so every
    // valid sample is taken; out_valid_o marks the cycle a fresh code appears.

    typedef logic signed [ACC_WIDTH-1:0] loop_t;

    localparam int    QSTEP  = 1 << QSHIFT;
    localparam loop_t L_HALF = loop_t'(QSTEP / 2);
    localparam loop_t L_QMAX = loop_t'(QMAX);
    localparam loop_t L_QMIN = loop_t'(-QMAX);
    localparam loop_t L_OVLP = loop_t'(OVL_LIMIT);
    localparam loop_t L_OVLN = loop_t'(-OVL_LIMIT);

    // ---------------- dither source ----------------
    logic [15:0]              w_lfsr;
    logic [15-DITHER_BITS:0]  w_lfsr_unused;
    logic [DITHER_BITS-1:0]   w_dither_bits;

    dem_dither_lfsr u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .adv_i   (in_valid_i),
        .lfsr_o  (w_lfsr)
    );

    assign w_dither_bits = w_lfsr[DITHER_BITS-1:0];
    assign w_lfsr_unused = w_lfsr[15:DITHER_BITS];

    // ---------------- stage 1: input + dither ----------------
    loop_t w_x_ext;
    loop_t w_dither;
    loop_t r_s1;
    logic  r_s1_valid;

    assign w_x_ext  = {{(ACC_WIDTH-INPUT_WIDTH){x_in_i[INPUT_WIDTH-1]}}, x_in_i};
    assign w_dither = dither_en_i
                    ? {{(ACC_WIDTH-DITHER_BITS){w_dither_bits[DITHER_BITS-1]}}, w_dither_bits}
                    : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= in_valid_i;
            if (in_valid_i) begin
                r_s1 <= w_x_ext + w_dither;
            end
        end
    end

    // ---------------- stage 2: loop filter, quantizer, overload ----------------
    loop_t r_e1;
    loop_t r_e2;
    loop_t w_v;
    loop_t w_v_round;
    loop_t w_q_raw;
    loop_t w_q;
    loop_t w_y;
    loop_t w_e;
    logic  w_ovl;

    always_comb begin
        w_v       = r_s1 - (r_e1 <<< 1) + r_e2;
        w_v_round = w_v + L_HALF;
        w_q_raw   = w_v_round >>> QSHIFT;
        w_q       = w_q_raw;
        if (w_q_raw > L_QMAX) begin
            w_q = L_QMAX;
        end else if (w_q_raw < L_QMIN) begin
            w_q = L_QMIN;
        end
        w_y   = w_q <<< QSHIFT;
        w_e   = w_y - w_v;
        w_ovl = (w_v > L_OVLP) || (w_v < L_OVLN);
    end

    logic signed [INPUT_WIDTH-1:0] r_x_out;
    logic                          r_out_valid;
    logic                          r_overflow;
    logic [7:0]                    r_ovl_count;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_e1        <= '0;
            r_e2        <= '0;
            r_x_out     <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_ovl_count <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_overflow  <= r_s1_valid && w_ovl;
            if (r_s1_valid) begin
                r_x_out <= {w_q[INPUT_WIDTH-2:0], 1'b0};
                // An overload dumps the loop memory so a runaway state cannot persist.
                if (w_ovl) begin
                    r_e1 <= '0;
                    r_e2 <= '0;
                    if (r_ovl_count != 8'hFF) begin
                        r_ovl_count <= r_ovl_count + 8'd1;
                    end
                end else begin
                    r_e2 <= r_e1;
                    r_e1 <= w_e;
                end
            end
        end
    end

    assign x_out_o     = r_x_out;
    assign out_valid_o = r_out_valid;
    assign overflow_o  = r_overflow;
    assign ovl_count_o = r_ovl_count;

endmodule
